fft_bitrev_reorder: RTL and testbench
=====================================

FFT_BITREV_REORDER -- requirements
Module: fft_bitrev_reorder

Interface
REQ-001 SHALL have parameter DATA_WIDTH, default `DATA_IN_WIDTH; the width of the real and imaginary sample fields.
REQ-002 SHALL have parameter LOG2_N, default `C2LOG_FFT_POINTS; N = 2^LOG2_N points per frame.
REQ-003 SHALL have port clk  input  1  sole clock; all state updates on its rising edge.
REQ-004 SHALL have port rstn  input  1  asynchronous active-low reset.
REQ-005 SHALL have port di_en  input  1  input sample valid, driven by the final SDF stage.
REQ-006 SHALL have port di_re / di_im  input  DATA_WIDTH each  sample in bit-reversed bin order.
REQ-007 SHALL have port do_en  output  1  output sample valid.
REQ-008 SHALL have port do_re / do_im  output  DATA_WIDTH each  sample in natural bin order.
REQ-009 SHALL have port do_last  output  1  high with bin N-1.
REQ-010 SHALL have port frame_err  output  1  one-cycle pulse when a partial frame is discarded.

Function
REQ-011 SHALL hold two banks (A, B) of N complex entries, ping-pong; each bank state is EMPTY, FULL or READING.
REQ-012 Write counter wcnt (LOG2_N bits) SHALL increment on each di_en cycle; the sample is written to address bitrev(wcnt) of the current write bank.
REQ-013 When di_en is high and wcnt = N-1: wcnt SHALL wrap to 0, the write bank SHALL become FULL, and the write pointer SHALL toggle to the other bank.
REQ-014 When di_en drops with 0 < wcnt: wcnt SHALL reset to 0, the partial frame SHALL be discarded (bank stays EMPTY), and frame_err SHALL pulse for 1 cycle.
REQ-015 Reader SHALL be an FSM with states IDLE and READ; IDLE -> READ when the bank at the read pointer is FULL; that bank becomes READING.
REQ-016 In READ the reader SHALL issue read address rcnt = 0..N-1 on consecutive cycles; after N-1 it SHALL mark the bank EMPTY, toggle the read pointer, and go to READ again if the next bank is FULL, else IDLE.
REQ-017 Bank read SHALL be synchronous; do_en/do_re/do_im/do_last SHALL be registered, with 1 cycle from address to output.
REQ-018 Latency: last sample of a frame accepted at cycle T -> bin 0 on do_* at cycle T+2; bins 1..N-1 SHALL follow with no gaps.
REQ-019 Back-to-back frames (continuous di_en) SHALL produce a continuous do_en stream with no dropped or duplicated samples.
REQ-020 A frame start into a bank that is not EMPTY SHALL NOT occur by construction; if it does, the frame SHALL be discarded and frame_err SHALL pulse at the frame's last sample.
REQ-021 When do_en = 0, do_re/do_im SHALL be 0 and do_last SHALL be 0.
REQ-022 Simultaneous frame completion and end of reader bank in the same cycle SHALL both take effect; the reader SHALL enter READ on the newly FULL bank without an IDLE cycle.

Reset
REQ-023 rstn low SHALL asynchronously clear: wcnt, rcnt, both pointers, bank states to EMPTY, FSM to IDLE, and all outputs to 0.
REQ-024 Reset mid-frame or mid-read SHALL discard all buffered data; after release, the first complete frame SHALL be output correctly.
REQ-025 RAM contents SHALL NOT require reset.

Configuration
REQ-026 With macro FFT_REORDER_IDX_EN defined, the module SHALL add output do_idx  LOG2_N  natural bin index, registered alongside do_re and equal to the read address of the sample; it SHALL be 0 when do_en = 0.
REQ-027 With FFT_REORDER_IDX_EN undefined, the do_idx port and its logic SHALL be absent; all other behaviour SHALL be identical.

Verification (LOG2_N=3, DATA_WIDTH=16)
REQ-028 Single frame: di_re = 0,4,2,6,1,5,3,7 and di_im = 10x di_re, over 8 cycles -> do_re = 0..7 and do_im = 0,10..70 starting 2 cycles after the last input; do_last is high on 7.
REQ-029 Three back-to-back frames with continuous di_en -> 24 consecutive do_en cycles with each frame in natural order; do_last on cycles 8, 16, 24.
REQ-030 di_en low after 5 samples -> frame_err high for 1 cycle and no output; the next full frame is output correctly.
REQ-031 rstn asserted during output bin 3 -> all outputs 0 immediately; a fresh frame after release is output correctly with 2-cycle latency.
REQ-032 Idle gap of 5 cycles between two frames -> two 8-sample bursts, each starting 2 cycles after its own last input.
REQ-033 With FFT_REORDER_IDX_EN defined, REQ-028 stimulus -> do_idx = 0..7 matching do_re.

Source files
------------

// File: rtl/fft_bitrev_reorder.sv
// Ping-pong reorder buffer turning bit-reversed SDF FFT output into natural bin order.
// Optional FFT_REORDER_IDX_EN adds a do_idx output carrying the natural bin index.
`ifndef DATA_IN_WIDTH
`define DATA_IN_WIDTH 16
`endif
`ifndef C2LOG_FFT_POINTS
`define C2LOG_FFT_POINTS 3
`endif

module fft_bitrev_reorder #(
  parameter int DATA_WIDTH = `DATA_IN_WIDTH,
  parameter int LOG2_N     = `C2LOG_FFT_POINTS
) (
  input  logic                  clk,
  input  logic                  rstn,
  input  logic                  di_en,
  input  logic [DATA_WIDTH-1:0] di_re,
  input  logic [DATA_WIDTH-1:0] di_im,
  output logic                  do_en,
  output logic [DATA_WIDTH-1:0] do_re,
  output logic [DATA_WIDTH-1:0] do_im,
`ifdef FFT_REORDER_IDX_EN
  output logic [LOG2_N-1:0]     do_idx,
`endif
  output logic                  do_last,
  output logic                  frame_err
);

  localparam int N = 32'd1 << LOG2_N;
  localparam logic [LOG2_N-1:0] LAST = {LOG2_N{1'b1}};
  localparam logic [LOG2_N-1:0] ZERO = {LOG2_N{1'b0}};
  localparam logic [LOG2_N-1:0] ONE  = LOG2_N'(1'b1);

  typedef enum logic [1:0] {
    BANK_EMPTY   = 2'd0,
    BANK_FULL    = 2'd1,
    BANK_READING = 2'd2
  } bank_t;

  typedef enum logic {
    RD_IDLE = 1'b0,
    RD_READ = 1'b1
  } rd_state_t;

  function automatic logic [LOG2_N-1:0] bitrev(input logic [LOG2_N-1:0] a);
    logic [LOG2_N-1:0] r;
    r = ZERO;
    for (int i = 0; i < LOG2_N; i++) begin
      r[i] = a[LOG2_N-1-i];
    end
    return r;
  endfunction

  logic [DATA_WIDTH-1:0] mem_re [2][N];
  logic [DATA_WIDTH-1:0] mem_im [2][N];

  logic [LOG2_N-1:0] wcnt_r, wcnt_nxt;
  logic              wptr_r, wptr_nxt;
  logic              drop_r, drop_nxt;
  logic [LOG2_N-1:0] rcnt_r, rcnt_nxt;
  logic              rptr_r, rptr_nxt;
  rd_state_t         rd_state_r, rd_state_nxt;
  bank_t             bank_r   [2];
  bank_t             bank_nxt [2];

  logic frame_start_s, rd_release_s, bank_free_s, drop_now_s;
  logic wr_en_s, frame_end_s, wr_done_s, err_s, next_ready_s, rd_en_s;

  // Writer: the frame-start check also accepts a bank whose final read address is issued this cycle
  always_comb begin
    frame_start_s = di_en && (wcnt_r == ZERO);
    rd_release_s  = (rd_state_r == RD_READ) && (rcnt_r == LAST);
    bank_free_s   = (bank_r[wptr_r] == BANK_EMPTY) ||
                    ((bank_r[wptr_r] == BANK_READING) && rd_release_s && (rptr_r == wptr_r));
    if (frame_start_s) begin
      drop_now_s = !bank_free_s;
    end else begin
      drop_now_s = drop_r;
    end
    wr_en_s     = di_en && !drop_now_s;
    frame_end_s = di_en && (wcnt_r == LAST);
    wr_done_s   = frame_end_s && !drop_now_s;
    err_s       = (frame_end_s && drop_now_s) || (!di_en && (wcnt_r != ZERO));
    if (di_en) begin
      wcnt_nxt = wcnt_r + ONE;
      drop_nxt = frame_end_s ? 1'b0 : drop_now_s;
    end else begin
      wcnt_nxt = ZERO;
      drop_nxt = 1'b0;
    end
    wptr_nxt = wr_done_s ? ~wptr_r : wptr_r;
  end

  // Reader FSM and bank-state bookkeeping; reader updates take priority over the writer's FULL mark
  always_comb begin
    rd_state_nxt = rd_state_r;
    rcnt_nxt     = rcnt_r;
    rptr_nxt     = rptr_r;
    bank_nxt     = bank_r;
    rd_en_s      = 1'b0;
    next_ready_s = (bank_r[~rptr_r] == BANK_FULL) || (wr_done_s && (wptr_r == ~rptr_r));
    if (wr_done_s) begin
      bank_nxt[wptr_r] = BANK_FULL;
    end else begin
      bank_nxt[wptr_r] = bank_r[wptr_r];
    end
    case (rd_state_r)
      RD_IDLE: begin
        rcnt_nxt = ZERO;
        if (bank_r[rptr_r] == BANK_FULL) begin
          rd_state_nxt     = RD_READ;
          bank_nxt[rptr_r] = BANK_READING;
        end else begin
          rd_state_nxt = RD_IDLE;
        end
      end
      RD_READ: begin
        rd_en_s = 1'b1;
        if (rcnt_r == LAST) begin
          rcnt_nxt         = ZERO;
          rptr_nxt         = ~rptr_r;
          bank_nxt[rptr_r] = BANK_EMPTY;
          if (next_ready_s) begin
            bank_nxt[~rptr_r] = BANK_READING;
            rd_state_nxt      = RD_READ;
          end else begin
            rd_state_nxt = RD_IDLE;
          end
        end else begin
          rcnt_nxt = rcnt_r + ONE;
        end
      end
      default: begin
        rd_state_nxt = RD_IDLE;
        rcnt_nxt     = ZERO;
      end
    endcase
  end

  // Control state registers
  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      wcnt_r     <= ZERO;
      wptr_r     <= 1'b0;
      drop_r     <= 1'b0;
      rcnt_r     <= ZERO;
      rptr_r     <= 1'b0;
      rd_state_r <= RD_IDLE;
      bank_r[0]  <= BANK_EMPTY;
      bank_r[1]  <= BANK_EMPTY;
    end else begin
      wcnt_r     <= wcnt_nxt;
      wptr_r     <= wptr_nxt;
      drop_r     <= drop_nxt;
      rcnt_r     <= rcnt_nxt;
      rptr_r     <= rptr_nxt;
      rd_state_r <= rd_state_nxt;
      bank_r[0]  <= bank_nxt[0];
      bank_r[1]  <= bank_nxt[1];
    end
  end

  // Sample storage, written at the bit-reversed address; no reset needed
  always_ff @(posedge clk) begin
    if (wr_en_s) begin
      mem_re[wptr_r][bitrev(wcnt_r)] <= di_re;
      mem_im[wptr_r][bitrev(wcnt_r)] <= di_im;
    end
  end

  // Synchronous bank read straight into the output registers, zeroed when not valid
  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      do_en     <= 1'b0;
      do_re     <= {DATA_WIDTH{1'b0}};
      do_im     <= {DATA_WIDTH{1'b0}};
      do_last   <= 1'b0;
      frame_err <= 1'b0;
`ifdef FFT_REORDER_IDX_EN
      do_idx    <= ZERO;
`endif
    end else begin
      frame_err <= err_s;
      do_en     <= rd_en_s;
      if (rd_en_s) begin
        do_re   <= mem_re[rptr_r][rcnt_r];
        do_im   <= mem_im[rptr_r][rcnt_r];
        do_last <= (rcnt_r == LAST);
`ifdef FFT_REORDER_IDX_EN
        do_idx  <= rcnt_r;
`endif
      end else begin
        do_re   <= {DATA_WIDTH{1'b0}};
        do_im   <= {DATA_WIDTH{1'b0}};
        do_last <= 1'b0;
`ifdef FFT_REORDER_IDX_EN
        do_idx  <= ZERO;
`endif
      end
    end
  end

endmodule

// File: tb/tb_fft_bitrev_reorder.sv
// Directed bench for fft_bitrev_reorder with N=8, 16-bit samples.
module tb_fft_bitrev_reorder;

  localparam int L = 40;

  logic        clk = 1'b0;
  logic        rstn;
  logic        di_en;
  logic [15:0] di_re, di_im;
  logic        do_en, do_last, frame_err;
  logic [15:0] do_re, do_im;
`ifdef FFT_REORDER_IDX_EN
  logic [2:0]  do_idx;
`endif

  fft_bitrev_reorder #(.DATA_WIDTH(16), .LOG2_N(3)) dut (
    .clk(clk), .rstn(rstn), .di_en(di_en), .di_re(di_re), .di_im(di_im),
    .do_en(do_en), .do_re(do_re), .do_im(do_im),
`ifdef FFT_REORDER_IDX_EN
    .do_idx(do_idx),
`endif
    .do_last(do_last), .frame_err(frame_err)
  );

  always #5 clk = ~clk;

  int n_cmp = 0;
  int n_mis = 0;
  int br [8] = '{0, 4, 2, 6, 1, 5, 3, 7};

  logic        s_en  [L];
  logic [15:0] s_re  [L];
  logic [15:0] s_im  [L];
  logic        e_en  [L];
  logic        e_last[L];
  logic        e_err [L];
  logic [15:0] e_re  [L];
  logic [15:0] e_im  [L];
  logic [2:0]  e_idx [L];

  task automatic check(input string tag, input int cyc, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_mis++;
      $error("FAIL %s cycle %0d: observed %0h expected %0h", tag, cyc, obs, exp);
    end
  endtask

  task automatic clear_scn();
    for (int i = 0; i < L; i++) begin
      s_en[i] = 1'b0; s_re[i] = 16'd0; s_im[i] = 16'd0;
      e_en[i] = 1'b0; e_last[i] = 1'b0; e_err[i] = 1'b0;
      e_re[i] = 16'd0; e_im[i] = 16'd0; e_idx[i] = 3'd0;
    end
  endtask

  // Input in bit-reversed order; a complete frame ending at cycle T shows bin k at cycle T+2+k
  task automatic put_frame(input int start, input int base, input int nsamp);
    for (int k = 0; k < nsamp; k++) begin
      s_en[start+k] = 1'b1;
      s_re[start+k] = 16'(base + br[k]);
      s_im[start+k] = 16'(10 * (base + br[k]));
    end
    if (nsamp == 8) begin
      for (int k = 0; k < 8; k++) begin
        e_en[start+9+k]   = 1'b1;
        e_re[start+9+k]   = 16'(base + k);
        e_im[start+9+k]   = 16'(10 * (base + k));
        e_idx[start+9+k]  = 3'(k);
        e_last[start+9+k] = (k == 7);
      end
    end else begin
      e_err[start+nsamp] = 1'b1;
    end
  endtask

  task automatic run_scn(input string name, input int n);
    for (int i = 0; i < n; i++) begin
      di_en = s_en[i];
      di_re = s_re[i];
      di_im = s_im[i];
      @(posedge clk);
      #1;
      check({name, ".en"},   i, 32'(do_en),     32'(e_en[i]));
      check({name, ".re"},   i, 32'(do_re),     32'(e_re[i]));
      check({name, ".im"},   i, 32'(do_im),     32'(e_im[i]));
      check({name, ".last"}, i, 32'(do_last),   32'(e_last[i]));
      check({name, ".err"},  i, 32'(frame_err), 32'(e_err[i]));
`ifdef FFT_REORDER_IDX_EN
      check({name, ".idx"},  i, 32'(do_idx),    32'(e_idx[i]));
`endif
    end
    di_en = 1'b0;
    di_re = 16'd0;
    di_im = 16'd0;
  endtask

  initial begin
    rstn  = 1'b0;
    di_en = 1'b0;
    di_re = 16'd0;
    di_im = 16'd0;
    #3;
    check("rst.en",   0, 32'(do_en),     32'd0);
    check("rst.re",   0, 32'(do_re),     32'd0);
    check("rst.im",   0, 32'(do_im),     32'd0);
    check("rst.last", 0, 32'(do_last),   32'd0);
    check("rst.err",  0, 32'(frame_err), 32'd0);
    @(posedge clk);
    #1;
    rstn = 1'b1;

    clear_scn();
    put_frame(0, 0, 8);
    run_scn("single", 20);

    clear_scn();
    put_frame(0, 0, 8);
    put_frame(8, 100, 8);
    put_frame(16, 200, 8);
    run_scn("b2b", 36);

    clear_scn();
    put_frame(0, 0, 5);
    put_frame(7, 20, 8);
    run_scn("partial", 26);

    clear_scn();
    put_frame(0, 40, 8);
    put_frame(13, 60, 8);
    run_scn("gap", 32);

    // Stop right after bin 3 appears, then pull reset between clock edges
    clear_scn();
    put_frame(0, 0, 8);
    run_scn("prereset", 13);
    rstn = 1'b0;
    #1;
    check("midrst.en",   0, 32'(do_en),     32'd0);
    check("midrst.re",   0, 32'(do_re),     32'd0);
    check("midrst.im",   0, 32'(do_im),     32'd0);
    check("midrst.last", 0, 32'(do_last),   32'd0);
    check("midrst.err",  0, 32'(frame_err), 32'd0);
    @(posedge clk);
    @(posedge clk);
    #1;
    rstn = 1'b1;

    clear_scn();
    put_frame(0, 30, 8);
    run_scn("postrst", 20);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_mis);
    $finish;
  end

endmodule
